lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store controller sitting directly upstream of the 4 KB word-addressed data memory.
//  Turns byte, halfword and word requests from the datapath into word accesses on the memory port.
//  - Sub-word stores: read-modify-write.
//  - Loads: byte-lane extraction and sign/zero extension.
//  - Results are registered and returned on a valid-only response channel.
// PARAMETERS
//  ADDR_W       12   byte-address width; memory word address is ADDR_W-2 bits (1024 words)
//  RESET_RDATA  0    value of rsp_rdata after reset
// PORTS
//  clk          in   1         clock, all state updates on posedge
//  rst_n        in   1         asynchronous, active-low reset
//  req_valid    in   1         request present
//  req_ready    out  1         request accepted when req_valid && req_ready
//  req_we       in   1         1 = store, 0 = load
//  req_size     in   2         00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned in   1         loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr     in   ADDR_W    byte address
//  req_wdata    in   32        store data, right-aligned (bits 7:0 / 15:0 / 31:0)
//  rsp_valid    out  1         one-cycle pulse: request complete
//  rsp_err      out  1         valid with rsp_valid: request rejected, no memory access
//  rsp_rdata    out  32        load result; holds its value until the next load completes
//  mem_addr     out  ADDR_W-2  word address to memory (= latched req_addr[ADDR_W-1:2])
//  mem_din      out  32        write data to memory
//  mem_we       out  1         memory write enable; memory writes on posedge clk
//  mem_dout     in   32        combinational read data from memory
// BEHAVIOUR
//  - Endianness: little-endian lanes; byte at addr[1:0]=k occupies bits 8k+7:8k.
//    Halfword at addr[1]=h occupies bits 16h+15:16h.
//  - FSM states: IDLE, LOAD, MERGE, WRITE, RESP, ERR.
//  - IDLE: req_ready=1. On accept, latch we/size/unsigned/addr/wdata, then go to:
//    - ERR if misaligned (see CONFIGURATION);
//    - LOAD for a load;
//    - WRITE for a word store;
//    - MERGE for a byte/half store.
//    req_ready=0 in every other state; no pipelining, one request in flight.
//  - LOAD: capture mem_dout, extract lane, extend to 32 bits into rsp_rdata -> RESP.
//  - MERGE: take mem_dout, replace the addressed lane(s) with wdata, hold the merged word in wdata -> WRITE.
//  - WRITE: mem_we=1 with mem_din = wdata register, for exactly one cycle -> RESP.
//  - RESP: rsp_valid=1, rsp_err=0 -> IDLE.
//  - ERR: rsp_valid=1, rsp_err=1, mem_we stays 0 -> IDLE.
//  - Latency, counted from the accept edge N (rsp_valid high in cycle):
//    - load, word store: N+2;
//    - byte/half store: N+3;
//    - error: N+1.
//    A new request can be accepted in the cycle after rsp_valid.
//  - mem_we is decoded from state only; it is never 1 outside WRITE.
//  - Reset (async, any state): state=IDLE, rsp_valid=0, rsp_err=0, mem_we=0, rsp_rdata=RESET_RDATA.
//    - Latched request registers are cleared to 0.
//    - A store interrupted before WRITE leaves memory untouched.
//  - Request inputs are ignored while req_ready=0.
// CONFIGURATION
//  Macro LSU_MISALIGN_TRAP_EN:
//  - Defined: a request goes to ERR if it is
//    - a half with addr[0]=1;
//    - a word with addr[1:0]!=0;
//    - size 11 (any address).
//  - Undefined: no ERR state and rsp_err is tied 0.
//    - Half: addr[0] is ignored.
//    - Word: addr[1:0] is ignored.
//    - Size 11: executes as a word access.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> immediately rsp_valid=0, mem_we=0, rsp_rdata=0; req_ready=1 after release.
//  2 sw 0xDEADBEEF @0x010, then lw @0x010 -> word 4 = 0xDEADBEEF; rsp_valid at N+2 each; rsp_rdata=0xDEADBEEF.
//  3 Word 0x010 = 0x11223344; sb 0x80 @0x013 -> word = 0x80223344 (rsp at N+3);
//    then lb @0x013 -> 0xFFFFFF80; lbu @0x013 -> 0x00000080.
//  4 sh 0xA5A5 @0x012 over 0x11223344 -> word 0xA5A53344;
//    lh @0x012 -> 0xFFFFA5A5; lhu @0x010 -> 0x00003344.
//  5 lw @0x011 with LSU_MISALIGN_TRAP_EN -> rsp_valid and rsp_err at N+1, mem_we never 1, rsp_rdata unchanged;
//    without the macro -> returns the word @0x010.
//  6 sb @0x010 with rst_n pulsed low while in MERGE -> mem_we never asserted, memory unchanged,
//    FSM back in IDLE, next lw returns the old value.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
// Request/response channel between the datapath and the load/store controller.
//   req_valid    datapath -> lsu  request present
//   req_ready    lsu -> datapath  request accepted when req_valid && req_ready
//   req_we       datapath -> lsu  1 = store, 0 = load
//   req_size     datapath -> lsu  00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned datapath -> lsu  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr     datapath -> lsu  byte address
//   req_wdata    datapath -> lsu  store data, right-aligned
//   rsp_valid    lsu -> datapath  one-cycle completion pulse
//   rsp_err      lsu -> datapath  request rejected (with rsp_valid)
//   rsp_rdata    lsu -> datapath  last load result
// Modports: master = datapath side, slave = controller side.
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
   parameter int ADDR_W = 12
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_err;
   logic [31:0]       rsp_rdata;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store controller in front of a word-addressed data memory. Turns byte,
// halfword and word requests into word accesses: sub-word stores are done as
// read-modify-write, loads get lane extraction plus sign/zero extension.
// One request in flight; results come back on a valid-only response channel.
//
// Ports
//   clk       clock, all state updates on posedge
//   rst_n     asynchronous active-low reset
//   bus       lsu_ctrl_if.slave request/response channel
//   mem_addr  word address to memory (latched req_addr[ADDR_W-1:2])
//   mem_din   write data to memory
//   mem_we    memory write enable, high only in WRITE
//   mem_dout  combinational read data from memory
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// requests and size 11 through an ERR state (rsp_err=1, no memory access).
// Without it, the low address bits below the access size are ignored, size 11
// behaves as a word, and rsp_err is tied low.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int          ADDR_W      = 12,
   parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_ctrl_if.slave         bus,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_we,
   input  logic [31:0]       mem_dout
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MERGE = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
`ifdef LSU_MISALIGN_TRAP_EN
      , ERR = 3'd5
`endif
   } state_t;

   state_t            state_q, state_d;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              ready_q;
   logic              rsp_valid_q;
   logic              mem_we_q;
   logic              accept_s;

   // Pick the addressed lane out of a memory word and extend it to 32 bits.
   // Size 11 only reaches here when trapping is disabled and acts as a word.
   function automatic logic [31:0] load_extract(
      input logic [31:0] word,
      input logic [1:0]  size,
      input logic [1:0]  lane,
      input logic        uns
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0000, h}    : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Overlay right-aligned store data onto the addressed lane(s) of a word.
   function automatic logic [31:0] merge_lane(
      input logic [31:0] word,
      input logic [31:0] wd,
      input logic [1:0]  size,
      input logic [1:0]  lane
   );
      logic [31:0] r;
      r = word;
      case (size)
         2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
         2'b01: begin
            if (lane[1]) begin
               r[31:16] = wd[15:0];
            end else begin
               r[15:0] = wd[15:0];
            end
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   assign accept_s = (state_q == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_s;
   logic rsp_err_q;

   // Alignment check on the incoming request, evaluated at accept.
   always_comb begin
      misalign_s = 1'b0;
      case (bus.req_size)
         2'b00:   misalign_s = 1'b0;
         2'b01:   misalign_s = bus.req_addr[0];
         2'b10:   misalign_s = |bus.req_addr[1:0];
         2'b11:   misalign_s = 1'b1;
         default: misalign_s = 1'b1;
      endcase
   end

   // Error flag follows the FSM into ERR, registered alongside rsp_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= (state_d == ERR);
      end
   end

   assign bus.rsp_err = rsp_err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   // Next-state decode. Word-sized stores skip the read phase entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
`ifdef LSU_MISALIGN_TRAP_EN
               if (misalign_s) begin
                  state_d = ERR;
               end else
`endif
               if (!bus.req_we) begin
                  state_d = LOAD;
               end else if (bus.req_size[1]) begin
                  state_d = WRITE;
               end else begin
                  state_d = MERGE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         LOAD:    state_d = RESP;
         MERGE:   state_d = WRITE;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
         ERR:     state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   // State register and state-decoded handshake/write-enable outputs,
   // registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= (state_d == IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
         rsp_valid_q <= (state_d == RESP) || (state_d == ERR);
`else
         rsp_valid_q <= (state_d == RESP);
`endif
         mem_we_q    <= (state_d == WRITE);
      end
   end

   // Request latch; in MERGE the store data register is overwritten with the
   // full merged word so WRITE always drives wdata_q unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0000_0000;
      end else if (accept_s) begin
         we_q    <= bus.req_we;
         size_q  <= bus.req_size;
         uns_q   <= bus.req_unsigned;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end else if (state_q == MERGE) begin
         wdata_q <= merge_lane(mem_dout, wdata_q, size_q, addr_q[1:0]);
      end
   end

   // Load result register; only a completing load updates it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= RESET_RDATA;
      end else if ((state_q == LOAD) && !we_q) begin
         rdata_q <= load_extract(mem_dout, size_q, addr_q[1:0], uns_q);
      end
   end

   assign mem_addr      = addr_q[ADDR_W-1:2];
   assign mem_din       = wdata_q;
   assign mem_we        = mem_we_q;
   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;

endmodule
